// File: rtl/btn_debounce_multi_pkg.sv
// Shared button-conditioner definitions: FSM state encoding, board default
// timing constants and the counter-width helper used by each channel.
package ctrl_btn_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW,
        PEND_HIGH,
        HELD,
        PEND_LOW
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 650960;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One counter width covers both debounce and repeat terminal counts.
    function automatic int cnt_width(input int db, input int dly, input int per);
        return $clog2(max3(db, dly, per) + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_multi_if.sv
// Button bundle between the board pins and the paddle/menu logic.
// master = pin/consumer side, slave = conditioner side.
interface btn_debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_press;
    logic [N_CH-1:0] btn_release;
    logic [N_CH-1:0] btn_repeat;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: reset-to-released synchroniser, symmetric debounce FSM
// and optional auto-repeat timer, all outputs registered.
module btn_debounce_ch
    import ctrl_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DB_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_TERM = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_TERM = CNT_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    btn_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_rep_cnt;
    logic                   r_rep_phase;
    logic                   w_s;
    logic [CNT_W-1:0]       w_rep_term;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_rep_term = r_rep_phase ? PER_TERM : DLY_TERM;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE_LOW;
            r_cnt       <= '0;
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
            o_level     <= 1'b0;
            o_press     <= 1'b0;
            o_release   <= 1'b0;
            o_repeat    <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_repeat  <= 1'b0;
            case (r_state)
                IDLE_LOW: begin
                    if (w_s) begin
                        r_state <= PEND_HIGH;
                        r_cnt   <= '0;
                    end
                end
                PEND_HIGH: begin
                    if (!w_s) begin
                        r_state <= IDLE_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_TERM) begin
                        r_state     <= HELD;
                        r_cnt       <= '0;
                        r_rep_cnt   <= '0;
                        r_rep_phase <= 1'b0;
                        o_level     <= 1'b1;
                        o_press     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!w_s) begin
                        r_state   <= PEND_LOW;
                        r_cnt     <= '0;
                        r_rep_cnt <= '0;
                    end else if (REPEAT_EN != 0) begin
                        // Phase flag switches the terminal from first delay to period.
                        if (r_rep_cnt == w_rep_term) begin
                            o_repeat    <= 1'b1;
                            r_rep_cnt   <= '0;
                            r_rep_phase <= 1'b1;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end
                end
                PEND_LOW: begin
                    // A bounce back high resumes HELD; the repeat phase is kept.
                    if (w_s) begin
                        r_state   <= HELD;
                        r_cnt     <= '0;
                        r_rep_cnt <= '0;
                    end else if (r_cnt == DB_TERM) begin
                        r_state   <= IDLE_LOW;
                        r_cnt     <= '0;
                        o_level   <= 1'b0;
                        o_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel button conditioner top: polarity select on the raw pins, then one
// independent debounce/repeat channel per button.
module btn_debounce_multi
    import ctrl_btn_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input logic           clk,
    input logic           rst,
    btn_debounce_multi_if.slave bus
);
    logic [N_CH-1:0] w_pin;
    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_press;
    logic [N_CH-1:0] w_release;
    logic [N_CH-1:0] w_repeat;

    // Inversion happens ahead of the synchroniser so "1 = pressed" everywhere after.
    assign w_pin = (ACTIVE_LOW != 0) ? ~bus.btn_in : bus.btn_in;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_pin     (w_pin[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g]),
            .o_repeat  (w_repeat[g])
        );
    end

    assign bus.btn_level   = w_level;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;
    assign bus.btn_repeat  = w_repeat;
endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: an active-high and an active-low instance;
// expected pulses are queued with their cycle and matched by a monitor.
`timescale 1ns/1ps
module tb_btn_debounce_multi;
    localparam int N_CH  = 2;
    localparam int DB    = 8;
    localparam int SYNC  = 2;
    localparam int RDLY  = 20;
    localparam int RPER  = 5;
    localparam int LAT   = SYNC + DB + 1;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_REP   = 2;

    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   rep_seen = 0;
    int   exp_q[$];

    btn_debounce_multi_if #(.N_CH(N_CH)) ifa();
    btn_debounce_multi_if #(.N_CH(N_CH)) ifb();

    btn_debounce_multi #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SYNC), .ACTIVE_LOW(0),
        .REPEAT_EN(1), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    btn_debounce_multi #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SYNC), .ACTIVE_LOW(1),
        .REPEAT_EN(1), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
    ) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] m_press, m_rel, m_rep, m_lvl;
    assign m_press = {ifb.btn_press,   ifa.btn_press};
    assign m_rel   = {ifb.btn_release, ifa.btn_release};
    assign m_rep   = {ifb.btn_repeat,  ifa.btn_repeat};
    assign m_lvl   = {ifb.btn_level,   ifa.btn_level};

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic expect_ev(input int c, input int ch, input int k);
        exp_q.push_back(c * 16 + ch * 4 + k);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse seen must match the head of the expected-event queue.
    initial begin
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < 4; ch++) begin
                for (int k = 0; k < 3; k++) begin
                    logic p;
                    int   got;
                    int   e;
                    p = (k == K_PRESS) ? m_press[ch] : (k == K_REL) ? m_rel[ch] : m_rep[ch];
                    if (p === 1'b1) begin
                        got = cyc * 16 + ch * 4 + k;
                        if (k == K_REP && ch == 1) rep_seen++;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL event: unexpected pulse cyc %0d ch %0d kind %0d, expected none",
                                     cyc, ch, k);
                        end else begin
                            e = exp_q.pop_front();
                            if (e == got) n_pass++;
                            else $display("FAIL event: got cyc %0d ch %0d kind %0d, expected cyc %0d ch %0d kind %0d",
                                          cyc, ch, k, e / 16, (e / 4) % 4, e % 4);
                        end
                        chk($sformatf("level_at_pulse ch%0d kind%0d", ch, k),
                            int'(m_lvl[ch]), (k == K_REL) ? 0 : 1);
                    end
                end
            end
        end
    end

    initial begin
        int t;
        int t2;
        ifa.btn_in = '0;
        ifb.btn_in = '1;
        rst   = 1'b1;
        rst_b = 1'b1;
        step(3);
        chk("reset_outs_a", int'({ifa.btn_level, ifa.btn_press, ifa.btn_release, ifa.btn_repeat}), 0);
        chk("reset_outs_b", int'({ifb.btn_level, ifb.btn_press, ifb.btn_release, ifb.btn_repeat}), 0);
        rst   = 1'b0;
        rst_b = 1'b0;
        step(2);

        // Clean press on ch0, then release with bounce
        t = cyc;
        ifa.btn_in[0] = 1'b1;
        expect_ev(t + LAT, 0, K_PRESS);
        step(LAT - 1);
        chk("press_not_early", int'(ifa.btn_level[0]), 0);
        step(1);
        chk("press_level", int'(ifa.btn_level[0]), 1);
        chk("ch1_unaffected", int'(ifa.btn_level[1]), 0);
        step(2);
        ifa.btn_in[0] = 1'b0;
        step(3);
        ifa.btn_in[0] = 1'b1;
        step(2);
        ifa.btn_in[0] = 1'b0;
        t2 = cyc;
        expect_ev(t2 + LAT, 0, K_REL);
        step(LAT - 1);
        chk("release_not_early", int'(ifa.btn_level[0]), 1);
        step(1);
        chk("release_level", int'(ifa.btn_level[0]), 0);
        step(5);

        // Glitch on ch0, then a full-latency press proves the counter restarted
        ifa.btn_in[0] = 1'b1;
        step(5);
        ifa.btn_in[0] = 1'b0;
        step(15);
        chk("glitch_level", int'(ifa.btn_level[0]), 0);
        t = cyc;
        ifa.btn_in[0] = 1'b1;
        expect_ev(t + LAT, 0, K_PRESS);
        step(LAT);
        chk("press2_level", int'(ifa.btn_level[0]), 1);
        t = cyc;
        ifa.btn_in[0] = 1'b0;
        expect_ev(t + LAT, 0, K_REL);
        step(LAT + 3);

        // Auto-repeat on ch1 held for 60 cycles
        t = cyc;
        ifa.btn_in[1] = 1'b1;
        expect_ev(t + LAT, 1, K_PRESS);
        for (int i = 0; i < 7; i++) expect_ev(t + LAT + RDLY + i * RPER, 1, K_REP);
        step(60);
        ifa.btn_in[1] = 1'b0;
        expect_ev(t + 60 + LAT, 1, K_REL);
        step(LAT + 5);
        chk("repeat_count", rep_seen, 7);
        chk("repeat_ch0_idle", int'(ifa.btn_level[0]), 0);

        // Active-low instance: press, reset while held, fresh press, release
        t = cyc;
        ifb.btn_in[0] = 1'b0;
        expect_ev(t + LAT, 2, K_PRESS);
        step(LAT);
        chk("al_press_level", int'(ifb.btn_level[0]), 1);
        chk("al_ch1_idle", int'(ifb.btn_level[1]), 0);
        step(4);
        rst_b = 1'b1;
        step(1);
        chk("al_reset_outs", int'({ifb.btn_level, ifb.btn_press, ifb.btn_release, ifb.btn_repeat}), 0);
        rst_b = 1'b0;
        t = cyc;
        expect_ev(t + LAT, 2, K_PRESS);
        step(LAT - 1);
        chk("al_repress_not_early", int'(ifb.btn_level[0]), 0);
        step(1);
        chk("al_repress_level", int'(ifb.btn_level[0]), 1);
        ifb.btn_in[0] = 1'b1;
        t = cyc;
        expect_ev(t + LAT, 2, K_REL);
        step(LAT + 5);
        chk("al_released", int'(ifb.btn_level[0]), 0);

        step(10);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
Parametrised N-channel button conditioner for the controller board. It replaces single-button, press-only debouncing with the following per channel:
- input synchroniser and polarity select;
- symmetric press/release debounce;
- one-cycle press and release pulses;
- optional auto-repeat while a button is held (paddle up/down hold).

It sits between the raw board pins and the paddle/menu control logic.

Parameters:
N_CH, 4, number of independent button channels
DEBOUNCE_CYCLES, 650960, consecutive stable synchronised samples required to accept a level change (>=1)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
ACTIVE_LOW, 0, 1 = raw pin reads 0 when pressed (inverted before synchroniser)
REPEAT_EN, 0, 1 = enable auto-repeat pulses while held
REPEAT_DELAY, 25000000, cycles held after the press pulse before the first repeat pulse (>=1)
REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
btn_in  in  N_CH  raw asynchronous button pins
btn_level  out  N_CH  debounced pressed level, 1 = pressed
btn_press  out  N_CH  1-cycle pulse on accepted press
btn_release  out  N_CH  1-cycle pulse on accepted release
btn_repeat  out  N_CH  1-cycle auto-repeat pulse; constant 0 when REPEAT_EN=0

Behaviour:
- Channels are fully independent; there is no cross-channel interaction.
- Polarity: each pin is inverted when ACTIVE_LOW=1, before entering the synchroniser.
- Synchroniser output: s[i].
- Reset:
  - all synchroniser flops reset to 0 (not pressed);
  - all FSMs reset to IDLE_LOW;
  - all counters reset to 0;
  - all outputs reset to 0.
- Counter width: CNT_W = $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1), derived locally. Counters never wrap; each is cleared on every state change.
- FSM per channel:
  - IDLE_LOW:
    - s=1 -> PEND_HIGH, cnt=0.
  - PEND_HIGH:
    - s=0 -> IDLE_LOW, cnt=0 (glitch discarded, no pulse).
    - else if cnt==DEBOUNCE_CYCLES-1 -> HELD: btn_level<=1, btn_press<=1 for one cycle, rep_cnt=0.
    - else cnt++.
  - HELD:
    - s=0 -> PEND_LOW, cnt=0.
    - else if REPEAT_EN, rep_cnt counts:
      - first btn_repeat pulse when rep_cnt reaches REPEAT_DELAY-1, then rep_cnt=0;
      - subsequent pulses every REPEAT_PERIOD cycles (terminal REPEAT_PERIOD-1).
  - PEND_LOW:
    - s=1 -> HELD; btn_level stays 1, no pulses, repeat timer restarts at 0 in the same phase it was in.
    - else if cnt==DEBOUNCE_CYCLES-1 -> IDLE_LOW: btn_level<=0, btn_release<=1 for one cycle.
    - else cnt++.
- Latency: with btn_in stable from edge 1, btn_level and btn_press assert after clock edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Release latency is identical.
- Pulse ordering: btn_press and btn_release are never both 1 on the same cycle of a channel. btn_repeat never coincides with btn_press.
- Repeat phase: a 1-bit flag distinguishes first-delay from period phase. It is cleared on entry to HELD from PEND_HIGH.
- Reset mid-operation: synchronous reset overrides all transitions; no pulse is emitted on the reset cycle. A button still held after reset is re-debounced and produces a fresh press pulse.
- All outputs are registered.

Decomposition:
- Shared package ctrl_btn_pkg:
  - typedef enum logic [1:0] {IDLE_LOW, PEND_HIGH, HELD, PEND_LOW} btn_state_t;
  - the default DEBOUNCE/REPEAT constants, shared with the controller top.
- Sub-module btn_debounce_ch:
  - contains one channel: synchroniser, FSM, counters;
  - instantiated N_CH times via generate;
  - the top adds only the polarity inversion and port slicing.

Test Plan:
- Bench parameters: N_CH=2, DEBOUNCE_CYCLES=8, SYNC_STAGES=2, REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Clean press, ch0 held from edge 1 -> btn_level[0]=1 and btn_press[0] pulse exactly after edge 11; btn_release/btn_repeat stay 0; ch1 unaffected.
- Glitch: ch0 high for 5 cycles then low -> no btn_level change, no pulses; counter restarts on the next press.
- Release bounce: ch0 held, then low 3 cycles / high 2 / low steady -> single btn_release pulse 11 edges after the final low; btn_level falls the same cycle; no repeat glitch.
- Auto-repeat: ch1 held 60 cycles -> press pulse, first btn_repeat 20 cycles after press, then every 5 cycles (7 pulses total before release).
- ACTIVE_LOW=1 instance: pin driven 0 -> press as in the clean-press case; reset driven 1 cycle while held -> outputs 0 next cycle, then a fresh press pulse 11 edges after reset deasserts.
